// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t       : fetch sequencer states
//   PCSRC_*       : next-PC select encodings driven by the controller
//   TRAP_*        : trap cause codes reported on trap_cause
//   NOP_INSTR     : instruction held in Instr out of reset (addi x0,x0,0)
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    // JALR is selected by any code with bit 1 set (2'b1x).
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC computation for the fetch stage (purely combinational).
//   PC         in  32  current architectural PC
//   PCSrc      in  2   00 PC+4, 01 PC+ImmExt, 1x ALUResult with bit0 cleared
//   ImmExt     in  32  sign-extended immediate
//   ALUResult  in  32  JALR target
//   NextPC     out 32  selected next PC (modulo 2^32)
//   misaligned out 1   NextPC is not word aligned
module pc_next_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic [31:0] NextPC,
    output logic        misaligned
);

    always_comb begin
        NextPC = PC + 32'd4;
        case (PCSrc)
            PCSRC_PLUS4:  NextPC = PC + 32'd4;
            PCSRC_BRANCH: NextPC = PC + ImmExt;
            // Both 2'b10 and 2'b11 select the JALR target.
            default:      NextPC = ALUResult & ~32'd1;
        endcase
        misaligned = |NextPC[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing stage.
//   clk, reset         clock and synchronous active-high reset
//   PCSrc/ImmExt/ALUResult/exec_done   next-PC inputs from execute
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction memory handshake
//   Instr/PC/PCPlus4/instr_valid       held instruction presented to decode
//   halted/trap_cause/trap_addr        trap reporting (misaligned target, fetch timeout)
//   retired            count of accepted exec_done
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_addr,
    output logic [31:0] retired
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  timeout_cnt;
    logic [31:0] next_pc;
    logic        next_misaligned;

    pc_next_calc u_pc_next_calc (
        .PC         (PC),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .NextPC     (next_pc),
        .misaligned (next_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            trap_cause  <= TRAP_NONE;
            trap_addr   <= '0;
            retired     <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= FETCH;
                    timeout_cnt <= '0;
                end
                FETCH: begin
                    // An ack in the final timeout cycle still wins.
                    if (imem_ack) begin
                        Instr <= imem_rdata;
                        state <= ISSUE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        trap_cause <= TRAP_TIMEOUT;
                        trap_addr  <= PC;
                        state      <= HALT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        retired <= retired + 32'd1;
                        if (next_misaligned) begin
                            trap_cause <= TRAP_MISALIGN;
                            trap_addr  <= next_pc;
                            state      <= HALT;
                        end else begin
                            PC          <= next_pc;
                            timeout_cnt <= '0;
                            state       <= FETCH;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Request and valid are forced low while reset is held.
    assign imem_req    = (state == FETCH) && !reset;
    assign instr_valid = (state == ISSUE) && !reset;
    assign halted      = (state == HALT);
    assign imem_addr   = PC;
    assign PCPlus4     = PC + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        exec_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [31:0] trap_addr;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .ALUResult   (ALUResult),
        .exec_done   (exec_done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .halted      (halted),
        .trap_cause  (trap_cause),
        .trap_addr   (trap_addr),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present an ack with data for one cycle (DUT must be in FETCH).
    task automatic ack_word(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Retire the current instruction with the given next-PC select.
    task automatic retire(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
        exec_done = 1'b1;
        PCSrc     = sel;
        ImmExt    = imm;
        ALUResult = alu;
        tick();
        exec_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
        exec_done = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_req",     {31'd0, imem_req},    32'd0);
        chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",      PC,                   32'h0);
        chk("rst_instr",   Instr,                32'h0000_0013);
        chk("rst_retired", retired,              32'd0);
        chk("rst_halted",  {31'd0, halted},      32'd0);
        chk("rst_cause",   {30'd0, trap_cause},  32'd0);
        reset = 1'b0;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);

        // ---- first fetch, ack on 2nd FETCH cycle ----
        tick();
        chk("fetch1_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch1_addr", imem_addr,         32'h0);
        tick();
        chk("fetch2_req",  {31'd0, imem_req}, 32'd1);
        ack_word(32'h0050_0093);
        chk("issue_valid",   {31'd0, instr_valid}, 32'd1);
        chk("issue_instr",   Instr,                32'h0050_0093);
        chk("issue_req",     {31'd0, imem_req},    32'd0);
        chk("issue_retired", retired,              32'd0);

        // exec_done outside ISSUE is ignored: held instr stays, retired unchanged
        // ---- sequential PC+4 ----
        retire(2'b00, 32'h0, 32'h0);
        chk("seq_addr",    imem_addr,         32'h4);
        chk("seq_plus4",   PCPlus4,           32'h8);
        chk("seq_retired", retired,           32'd1);
        chk("seq_req",     {31'd0, imem_req}, 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("fetch_ign_exec", retired, 32'd1);
        ack_word(32'h0000_0013);
        retire(2'b00, 32'h0, 32'h0); ack_word(32'h0000_0013);   // -> 0x8
        retire(2'b00, 32'h0, 32'h0); ack_word(32'h0000_0013);   // -> 0xC
        retire(2'b00, 32'h0, 32'h0); ack_word(32'h0000_0013);   // -> 0x10
        chk("pc_0x10", PC, 32'h10);

        // ---- branch backwards and JALR ----
        retire(2'b01, 32'hFFFF_FFF8, 32'h0);
        chk("branch_pc", PC, 32'h8);
        ack_word(32'h0000_0013);
        retire(2'b10, 32'h0, 32'h0000_0101);
        chk("jalr_pc", PC, 32'h100);
        ack_word(32'h0000_0013);
        retire(2'b11, 32'h0, 32'h0000_0009);   // 2'b11 also selects JALR
        chk("jalr11_pc", PC, 32'h8);
        chk("retired_7", retired, 32'd7);
        ack_word(32'hDEAD_0013);

        // ---- misaligned branch target ----
        retire(2'b01, 32'h0000_0006, 32'h0);
        chk("mis_halted",  {31'd0, halted},     32'd1);
        chk("mis_cause",   {30'd0, trap_cause}, 32'd1);
        chk("mis_addr",    trap_addr,           32'hE);
        chk("mis_pc",      PC,                  32'h8);
        chk("mis_req",     {31'd0, imem_req},   32'd0);
        chk("mis_valid",   {31'd0, instr_valid},32'd0);
        chk("mis_retired", retired,             32'd8);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; exec_done = 1'b1;
        tick(); tick();
        imem_ack = 1'b0; exec_done = 1'b0;
        chk("halt_instr",   Instr,             32'hDEAD_0013);
        chk("halt_retired", retired,           32'd8);
        chk("halt_stays",   {31'd0, halted},   32'd1);
        chk("halt_req",     {31'd0, imem_req}, 32'd0);

        // ---- fetch timeout at PC=0x20 ----
        do_reset();
        chk("rst2_halted", {31'd0, halted},     32'd0);
        chk("rst2_cause",  {30'd0, trap_cause}, 32'd0);
        tick();
        ack_word(32'h0000_0013);
        retire(2'b01, 32'h0000_0020, 32'h0);    // FETCH cycle 1 at 0x20
        for (int i = 0; i < 15; i++) tick();    // now in FETCH cycle 16
        chk("to_c16_halted", {31'd0, halted},   32'd0);
        chk("to_c16_req",    {31'd0, imem_req}, 32'd1);
        tick();
        chk("to_halted", {31'd0, halted},     32'd1);
        chk("to_cause",  {30'd0, trap_cause}, 32'd2);
        chk("to_addr",   trap_addr,           32'h20);
        chk("to_req",    {31'd0, imem_req},   32'd0);

        // ---- ack exactly on the 16th FETCH cycle wins ----
        do_reset();
        tick();
        ack_word(32'h0000_0013);
        retire(2'b01, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        ack_word(32'hCAFE_0013);
        chk("ack16_halted", {31'd0, halted},      32'd0);
        chk("ack16_valid",  {31'd0, instr_valid}, 32'd1);
        chk("ack16_instr",  Instr,                32'hCAFE_0013);
        chk("ack16_cause",  {30'd0, trap_cause},  32'd0);

        // ---- silent wrap-around at top of address space ----
        retire(2'b01, 32'hFFFF_FFDC, 32'h0);    // 0x20 + (-0x24) = 0xFFFF_FFFC
        chk("wrap_pc",    PC,      32'hFFFF_FFFC);
        chk("wrap_plus4", PCPlus4, 32'h0);
        ack_word(32'h0000_0013);
        retire(2'b00, 32'h0, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);

        // ---- reset colliding with ack and exec_done ----
        ack_word(32'h0000_0013);
        reset = 1'b1; imem_ack = 1'b1; exec_done = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        tick();
        chk("rc_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rc_req",     {31'd0, imem_req},    32'd0);
        chk("rc_pc",      PC,                   32'h0);
        chk("rc_instr",   Instr,                32'h0000_0013);
        chk("rc_retired", retired,              32'd0);
        reset = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        #1;
        chk("rc_boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rc_fetch_req", {31'd0, imem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and PC-sequencing stage that sits directly upstream of the decode/controller logic. It owns the architectural PC and fetches from instruction memory over a req/ack handshake. It presents a held instruction to decode and, when execute signals completion, consumes the 2-bit PC-select encoding (00 = PC+4, 01 = PC+ImmExt for taken branch or JAL, 1x = JALR target) to form the next PC. It also detects misaligned targets and fetch timeouts and halts on either.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum FETCH cycles without imem_ack before a bus-error halt (range 1..255).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
PCSrc  in  2  next-PC select from controller: 00 PC+4, 01 PC+ImmExt, 1x ALUResult with bit0 cleared
ImmExt  in  32  sign-extended immediate
ALUResult  in  32  JALR target (rs1+imm)
exec_done  in  1  execute has consumed the current Instr; PCSrc/ImmExt/ALUResult are valid this cycle
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, always equals PC
imem_ack  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched word
Instr  out  32  held instruction to decode
PC  out  32  architectural PC of Instr
PCPlus4  out  32  PC+4, used as the link value
instr_valid  out  1  Instr/PC valid for execution
halted  out  1  core halted on trap
trap_cause  out  2  00 none, 01 misaligned target, 10 fetch timeout
trap_addr  out  32  offending target (misaligned) or PC (timeout)
retired  out  32  count of accepted exec_done

Behaviour:
- Reset (synchronous; wins over every other input in the same cycle, including imem_ack and exec_done):
  - Registers: PC=RESET_PC, Instr=32'h0000_0013 (NOP), state=BOOT, halted=0, trap_cause=0, trap_addr=0, retired=0, timeout counter=0.
  - Combinational outputs during reset: imem_req=0, instr_valid=0.
  - Reset mid-fetch abandons the request. imem_req is low in the first cycle after reset is released (BOOT).
- States: BOOT, FETCH, ISSUE, HALT.
- BOOT: lasts exactly one cycle, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=PC, instr_valid=0.
  - Timeout counter increments each FETCH cycle without an ack and is cleared on entry to FETCH.
  - On imem_ack: Instr<=imem_rdata, go to ISSUE. instr_valid rises the following cycle, so the minimum fetch latency is 1 cycle after req.
  - If TIMEOUT cycles elapse without an ack: trap_cause=10, trap_addr=PC, go to HALT. An ack arriving in the same cycle as the timeout is accepted; the ack wins.
- ISSUE:
  - imem_req=0, instr_valid=1. Instr and PC are held stable until exec_done.
  - On exec_done, compute NextPC:
    - PCSrc 00: PC+4.
    - PCSrc 01: PC+ImmExt.
    - PCSrc 10/11: {ALUResult[31:1],1'b0}.
  - All adds are modulo 2^32; wrap-around is silent (32'hFFFF_FFFC+4 = 0).
  - retired increments on every exec_done accepted in ISSUE, including a trapping one, and wraps silently.
  - If NextPC[1:0]!=0: PC is unchanged, trap_cause=01, trap_addr=NextPC, go to HALT.
  - Otherwise: PC<=NextPC, go to FETCH.
- HALT:
  - halted=1, imem_req=0, instr_valid=0.
  - Only reset exits this state.
- Ignored inputs:
  - imem_ack outside FETCH.
  - exec_done outside ISSUE.
- PCPlus4 is always PC+4, combinational from the PC register.

Decomposition:
- Shared package holds:
  - state enum (BOOT/FETCH/ISSUE/HALT);
  - PCSrc encodings (PCSRC_PLUS4=2'b00, PCSRC_BRANCH=2'b01, PCSRC_JALR=2'b1x);
  - trap cause codes (TRAP_NONE/TRAP_MISALIGN/TRAP_TIMEOUT);
  - NOP constant 32'h0000_0013.
- One combinational sub-module, pc_next_calc: inputs PC, PCSrc, ImmExt, ALUResult; outputs NextPC and misaligned.

Test Plan:
- Reset, then imem_ack on the 2nd FETCH cycle with rdata=32'h00500093 -> imem_addr=0 in FETCH; Instr=32'h00500093 with instr_valid=1; retired=0.
- exec_done with PCSrc=00 at PC=0x0, then ack -> next imem_addr=0x4, PCPlus4=0x8, retired=1.
- At PC=0x10, exec_done with PCSrc=01, ImmExt=32'hFFFF_FFF8 -> PC=0x8. Then PCSrc=10, ALUResult=0x101 -> PC=0x100.
- At PC=0x8, PCSrc=01, ImmExt=0x6 -> halted=1, trap_cause=01, trap_addr=0xE, PC stays 0x8, imem_req stays 0.
- No ack for 16 cycles at PC=0x20 -> halted=1, trap_cause=10, trap_addr=0x20. Separately, an ack exactly on the 16th cycle -> no trap, Instr is loaded.
- reset asserted in the same cycle as imem_ack and exec_done -> state BOOT, PC=RESET_PC, Instr=NOP, instr_valid=0, retired=0.
